// File: rtl/phase_seq.sv
// phase_seq: instruction phase sequencer for the multi-cycle core.
// Drives the datapath phase (0..NPHASE-1) while running and 3'b111 otherwise,
// stalls fetch/memory phases on mem_wait, honours stop/step/HLT at
// instruction boundaries and counts retired instructions.
module phase_seq #(
  parameter int NPHASE = 5,
  parameter int ICNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic              stop,
  input  logic              halt_dec,
  input  logic              mem_wait,
  output logic [2:0]        phase,
  output logic              phase_adv,
  output logic              instr_done,
  output logic              running,
  output logic              halted,
  output logic [ICNT_W-1:0] icount
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [2:0] PH_OFF  = 3'b111;
  localparam logic [2:0] PH_LAST = 3'(NPHASE - 1);

  state_t state;
  logic   single;
  logic   stop_pend;
  logic   halt_pend;
  logic   stall;
  logic   stop_now;

  // Stall and advance strobes, decoded combinationally from the current phase.
  assign stall      = mem_wait && (phase == 3'd0 || phase == 3'd3);
  assign phase_adv  = (state == ST_RUN) && !stall;
  assign instr_done = phase_adv && (phase == PH_LAST);
  // A stop arriving on the boundary cycle itself must still take effect.
  assign stop_now   = stop_pend || stop;

  // Sequencer state, phase counter, pending flags and retire counter.
  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would chain updates within a cycle.
    if (!rst_n) begin
      state     <= ST_IDLE;
      phase     <= PH_OFF;
      icount    <= '0;
      running   <= 1'b0;
      halted    <= 1'b0;
      single    <= 1'b0;
      stop_pend <= 1'b0;
      halt_pend <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_HALT: begin
          if (start || step) begin
            state   <= ST_RUN;
            phase   <= 3'd0;
            single  <= !start;
            running <= 1'b1;
            halted  <= 1'b0;
          end
        end

        ST_RUN: begin
          if (stop)
            stop_pend <= 1'b1;
          if (halt_dec && phase == 3'd1 && phase_adv)
            halt_pend <= 1'b1;

          if (phase_adv) begin
            if (phase == PH_LAST) begin
              icount    <= icount + ICNT_W'(1);
              single    <= 1'b0;
              stop_pend <= 1'b0;
              halt_pend <= 1'b0;
              if (halt_pend) begin
                state   <= ST_HALT;
                phase   <= PH_OFF;
                running <= 1'b0;
                halted  <= 1'b1;
              end else if (stop_now || single) begin
                state   <= ST_IDLE;
                phase   <= PH_OFF;
                running <= 1'b0;
              end else begin
                phase   <= 3'd0;
              end
            end else begin
              phase <= phase + 3'd1;
            end
          end
        end

        default: begin
          state   <= ST_IDLE;
          phase   <= PH_OFF;
          running <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_seq.sv
// tb_phase_seq: scoreboard bench for phase_seq (NPHASE=5, ICNT_W=4).
// Each driven cycle pushes the expected outputs for that cycle; a monitor
// pops and compares them after the inputs have settled, mid low-phase.
module tb_phase_seq;

  localparam int NPHASE = 5;
  localparam int ICNT_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, step, stop, halt_dec, mem_wait;
  logic [2:0]        phase;
  logic              phase_adv, instr_done, running, halted;
  logic [ICNT_W-1:0] icount;

  phase_seq #(.NPHASE(NPHASE), .ICNT_W(ICNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .step       (step),
    .stop       (stop),
    .halt_dec   (halt_dec),
    .mem_wait   (mem_wait),
    .phase      (phase),
    .phase_adv  (phase_adv),
    .instr_done (instr_done),
    .running    (running),
    .halted     (halted),
    .icount     (icount)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             tag;
    logic [2:0]        phase;
    logic              adv;
    logic              done;
    logic              run;
    logic              hlt;
    logic [ICNT_W-1:0] icnt;
  } exp_t;

  exp_t              sb_q[$];
  int                n_checks = 0;
  int                n_fail   = 0;
  int                obs_run_cyc = 0;
  int                obs_stalls  = 0;
  logic [ICNT_W-1:0] exp_icnt = '0;
  string             cur_tag = "reset";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: compare the oldest expectation against the settled outputs.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({e.tag, ".phase"},      32'(phase),      32'(e.phase));
      check({e.tag, ".phase_adv"},  32'(phase_adv),  32'(e.adv));
      check({e.tag, ".instr_done"}, 32'(instr_done), 32'(e.done));
      check({e.tag, ".running"},    32'(running),    32'(e.run));
      check({e.tag, ".halted"},     32'(halted),     32'(e.hlt));
      check({e.tag, ".icount"},     32'(icount),     32'(e.icnt));
      if (running) begin
        obs_run_cyc++;
        if (!phase_adv) obs_stalls++;
      end
    end
  end

  // Drive one cycle of inputs and record what the DUT must show during it.
  task automatic drive(input logic r, input logic st, input logic sp, input logic stp,
                       input logic hd, input logic mw, input exp_t e);
    @(negedge clk);
    rst_n    = r;
    start    = st;
    step     = sp;
    stop     = stp;
    halt_dec = hd;
    mem_wait = mw;
    e.tag    = cur_tag;
    sb_q.push_back(e);
  endtask

  // One cycle outside RUN: phase parked at 7, no strobes.
  task automatic idle_cyc(input logic r, input logic st, input logic sp,
                          input logic noise, input logic hlt_exp);
    exp_t e;
    e.phase = 3'b111; e.adv = 1'b0; e.done = 1'b0;
    e.run = 1'b0; e.hlt = hlt_exp; e.icnt = exp_icnt;
    drive(r, st, sp, noise, noise, noise, e);
  endtask

  // One full instruction in RUN. w0/w3: stall cycles in phase 0/3.
  // stop_ph: phase whose first cycle carries stop. hd_ph: phase whose advance
  // cycle carries halt_dec. hold_ss: start+step held throughout. mw2: mem_wait
  // in phase 2. rst_ph: assert reset on the first cycle of that phase and abort.
  task automatic run_instr(input int w0, input int w3, input int stop_ph, input int hd_ph,
                           input logic hold_ss, input logic mw2, input int rst_ph);
    for (int p = 0; p < NPHASE; p++) begin
      int nst;
      nst = (p == 0) ? w0 : ((p == 3) ? w3 : 0);
      for (int c = 0; c <= nst; c++) begin
        exp_t e;
        logic last, rst_here;
        last     = (c == nst);
        rst_here = (p == rst_ph) && (c == 0);
        e.phase = 3'(p); e.adv = last; e.done = last && (p == NPHASE - 1);
        e.run = 1'b1; e.hlt = 1'b0; e.icnt = exp_icnt;
        drive(!rst_here, hold_ss, hold_ss, (p == stop_ph) && (c == 0),
              (p == hd_ph) && last, !last || (p == 2 && mw2), e);
        if (rst_here) return;
      end
    end
    exp_icnt = exp_icnt + 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; step = 1'b0; stop = 1'b0;
    halt_dec = 1'b0; mem_wait = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, then continuous run of three plain instructions.
    cur_tag = "reset";
    idle_cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cur_tag = "start";
    idle_cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cur_tag = "run3";
    repeat (3) run_instr(0, 0, -1, -1, 1'b0, 1'b0, -1);
    @(posedge clk); #1;
    check("icount_after_3", 32'(icount), 32'd3);

    // Memory waits: 2 in fetch, 3 in memory phase, plus an ignored wait in phase 2.
    cur_tag = "memwait";
    obs_run_cyc = 0; obs_stalls = 0;
    run_instr(2, 3, -1, -1, 1'b0, 1'b1, -1);
    #3;
    check("memwait_cycles", 32'(obs_run_cyc), 32'd10);
    check("memwait_stalls", 32'(obs_stalls),  32'd5);

    // Stop requested in phase 1 finishes the instruction, then IDLE.
    cur_tag = "stop_p1";
    run_instr(0, 0, 1, -1, 1'b0, 1'b0, -1);
    idle_cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Single step with start/step held during RUN.
    cur_tag = "step";
    idle_cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_instr(0, 0, -1, -1, 1'b1, 1'b0, -1);
    idle_cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // start+step together runs continuously; stop during a phase-3 stall.
    cur_tag = "start_step";
    idle_cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    run_instr(0, 0, -1, -1, 1'b0, 1'b0, -1);
    run_instr(0, 0, -1, -1, 1'b0, 1'b0, -1);
    cur_tag = "stop_stall";
    run_instr(1, 2, 3, -1, 1'b0, 1'b0, -1);
    idle_cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stop on the final advance cycle.
    cur_tag = "stop_p4";
    idle_cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_instr(0, 0, 4, -1, 1'b0, 1'b0, -1);
    idle_cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // halt_dec outside phase 1 is ignored; in phase 1 it halts after retire.
    cur_tag = "hlt";
    idle_cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_instr(0, 0, -1, 0, 1'b0, 1'b0, -1);
    run_instr(0, 0, -1, 2, 1'b0, 1'b0, -1);
    run_instr(0, 0, -1, 1, 1'b0, 1'b0, -1);
    idle_cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // Resume from HALT; HLT plus stop in one instruction still halts.
    cur_tag = "hlt_stop";
    idle_cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    run_instr(0, 1, 1, 1, 1'b0, 1'b0, -1);
    idle_cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Step out of HALT clears halted and retires one instruction.
    cur_tag = "halt_step";
    idle_cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    run_instr(0, 0, -1, -1, 1'b0, 1'b0, -1);
    idle_cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during a phase-3 stall with a stop pending.
    cur_tag = "rst_mid";
    idle_cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_instr(0, 2, 1, -1, 1'b0, 1'b0, 3);
    exp_icnt = '0;
    idle_cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    check("icount_after_rst", 32'(icount), 32'd0);

    // 17 retirements on a 4-bit counter wraps to 1.
    cur_tag = "wrap";
    idle_cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (16) run_instr(0, 0, -1, -1, 1'b0, 1'b0, -1);
    run_instr(0, 0, 2, -1, 1'b0, 1'b0, -1);
    idle_cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    check("icount_wrap", 32'(icount), 32'd1);

    @(negedge clk); #3;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
